axis_governor: RTL and testbench
================================

AXIS_GOVERNOR -- requirements
Module: axis_governor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: width in bits of the tdata buses.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width in bits of the statistics counters.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rstn.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
  - clk  in  1  rising-edge clock.
  - rstn  in  1  asynchronous active-low reset.
  - s_tdata  in  DATA_WIDTH  input stream data.
  - s_tkeep  in  DATA_WIDTH/8  input stream byte enables.
  - s_tlast  in  1  input stream end-of-packet.
  - s_tvalid  in  1  input stream valid.
  - s_tready  out  1  input stream ready.
  - m_tdata  out  DATA_WIDTH  output stream data.
  - m_tkeep  out  DATA_WIDTH/8  output stream byte enables.
  - m_tlast  out  1  output stream end-of-packet.
  - m_tvalid  out  1  output stream valid.
  - m_tready  in  1  output stream ready.
  - pause  in  1  command: stall the input at the next packet boundary.
  - drop  in  1  command: discard packets starting at the next packet boundary.
  - log_valid  out  1  one-cycle pulse when a flit was accepted on the previous cycle.
  - log_tdata, log_tkeep, log_tlast  out  as s_*  copy of the accepted flit.
  - log_dropped  out  1  the logged flit was discarded rather than forwarded.
  - pkt_passed  out  CNT_WIDTH  count of packets forwarded.
  - pkt_dropped  out  CNT_WIDTH  count of packets discarded.

Function
REQ-005 SHALL define accept = s_tvalid & s_tready.
REQ-006 SHALL keep register in_pkt: set on accept with s_tlast=0, cleared on accept with s_tlast=1, otherwise held.
REQ-007 SHALL define cmd_mode = PAUSE if pause=1; else DROP if drop=1; else PASS (pause has priority over drop).
REQ-008 SHALL define eff_mode = pkt_mode when in_pkt=1, else cmd_mode; pkt_mode SHALL load eff_mode on every accept.
  - Commands take effect only at packet boundaries; a packet is never split between modes.
REQ-009 In PASS mode, SHALL connect m_tvalid=s_tvalid, s_tready=m_tready, and m_tdata/tkeep/tlast = s_* combinationally (zero latency, no buffering).
REQ-010 In PAUSE mode, SHALL drive s_tready=0 and m_tvalid=0.
REQ-011 In DROP mode, SHALL drive s_tready=1 and m_tvalid=0, consuming flits regardless of m_tready.
REQ-012 On each accept, SHALL register the flit to log_* with log_valid=1 and log_dropped=(eff_mode==DROP) on the next cycle; otherwise log_valid=0.
REQ-013 SHALL increment pkt_passed on an accept with s_tlast=1 in PASS mode, and increment pkt_dropped on the same event in DROP mode.
  - Counters wrap modulo 2^CNT_WIDTH.
REQ-014 A pause or drop asserted mid-packet SHALL NOT affect the current packet; it applies from the first flit after tlast.
  - Deassertion mid-packet likewise takes effect only after tlast.
REQ-015 A single-flit packet (tlast on the first flit) SHALL leave in_pkt=0 and use cmd_mode of that cycle.
REQ-016 m_* data outputs SHALL follow s_* in every mode; only m_tvalid is gated.

Reset
REQ-017 On rstn=0, SHALL asynchronously clear in_pkt, pkt_mode (to PASS), log_valid, log_* data, log_dropped, pkt_passed and pkt_dropped.
REQ-018 After reset, the block SHALL be at a packet boundary, so the first flit uses cmd_mode.
REQ-019 Reset asserted mid-packet SHALL abandon that packet; the remaining flits SHALL be treated as a new packet under cmd_mode.

Verification
REQ-020 Pass-through: pause=drop=0, 3-flit packet 0x11,0x22,0x33 with tlast on 0x33 -> identical flits on m_*, 3 log_valid pulses with log_dropped=0, pkt_passed=1.
REQ-021 Mid-packet pause: pause=1 asserted after the 1st of 4 flits -> all 4 flits forwarded; s_tready=0 from the following packet onward; the next packet is released when pause=0.
REQ-022 Drop: drop=1 at a boundary with m_tready=0 for a 2-flit packet -> s_tready=1, m_tvalid=0, both flits logged with log_dropped=1, pkt_dropped=1, pkt_passed unchanged.
REQ-023 Priority: pause=1 and drop=1 at a boundary -> PAUSE behaviour (s_tready=0), pkt_dropped unchanged.
REQ-024 Backpressure: PASS mode with m_tready toggling -> s_tready equals m_tready each cycle and no flit is lost or duplicated.
REQ-025 Reset mid-packet: rstn=0 after the 2nd flit of a 4-flit packet -> counters=0, log_valid=0, in_pkt=0; a subsequent drop=1 takes effect on the very next flit.

Source files
------------

// File: rtl/axis_governor.sv
// AXI-Stream packet governor: passes, pauses or drops whole packets on command,
// logging every accepted flit and counting forwarded and discarded packets.
module axis_governor #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic                      s_tlast,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    input  logic                      pause,
    input  logic                      drop,
    output logic                      log_valid,
    output logic [DATA_WIDTH-1:0]     log_tdata,
    output logic [DATA_WIDTH/8-1:0]   log_tkeep,
    output logic                      log_tlast,
    output logic                      log_dropped,
    output logic [CNT_WIDTH-1:0]      pkt_passed,
    output logic [CNT_WIDTH-1:0]      pkt_dropped
);

    localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_PAUSE = 2'd1,
        MODE_DROP  = 2'd2
    } mode_t;

    mode_t cmd_mode_c;
    mode_t eff_mode_c;
    mode_t pkt_mode;
    logic  in_pkt;
    logic  accept_c;

    // Commands only matter at a packet boundary; mid-packet the latched mode rules.
    always_comb begin
        cmd_mode_c = MODE_PASS;
        if (pause) begin
            cmd_mode_c = MODE_PAUSE;
        end else if (drop) begin
            cmd_mode_c = MODE_DROP;
        end
        eff_mode_c = in_pkt ? pkt_mode : cmd_mode_c;
    end

    // Handshake gating; data always follows the input so only valid/ready change.
    always_comb begin
        s_tready = 1'b0;
        m_tvalid = 1'b0;
        case (eff_mode_c)
            MODE_PASS: begin
                s_tready = m_tready;
                m_tvalid = s_tvalid;
            end
            MODE_DROP: begin
                s_tready = 1'b1;
            end
            default: begin
                s_tready = 1'b0;
                m_tvalid = 1'b0;
            end
        endcase
    end

    assign m_tdata  = s_tdata;
    assign m_tkeep  = s_tkeep;
    assign m_tlast  = s_tlast;
    assign accept_c = s_tvalid & s_tready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_pkt      <= 1'b0;
            pkt_mode    <= MODE_PASS;
            log_valid   <= 1'b0;
            log_tdata   <= '0;
            log_tkeep   <= KEEP_WIDTH'(0);
            log_tlast   <= 1'b0;
            log_dropped <= 1'b0;
            pkt_passed  <= '0;
            pkt_dropped <= '0;
        end else begin
            log_valid <= accept_c;
            if (accept_c) begin
                in_pkt      <= ~s_tlast;
                pkt_mode    <= eff_mode_c;
                log_tdata   <= s_tdata;
                log_tkeep   <= s_tkeep;
                log_tlast   <= s_tlast;
                log_dropped <= (eff_mode_c == MODE_DROP);
                if (s_tlast) begin
                    if (eff_mode_c == MODE_PASS) begin
                        pkt_passed <= pkt_passed + CNT_WIDTH'(1);
                    end
                    if (eff_mode_c == MODE_DROP) begin
                        pkt_dropped <= pkt_dropped + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_governor.sv
// Directed bench for axis_governor: pass, pause, drop, priority, backpressure
// and mid-packet reset, with hand-computed expectations.
module tb_axis_governor;

    localparam int unsigned DW = 64;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic          pause;
    logic          drop;
    logic          log_valid;
    logic [DW-1:0] log_tdata;
    logic [KW-1:0] log_tkeep;
    logic          log_tlast;
    logic          log_dropped;
    logic [CW-1:0] pkt_passed;
    logic [CW-1:0] pkt_dropped;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_governor #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .pause(pause), .drop(drop),
        .log_valid(log_valid), .log_tdata(log_tdata), .log_tkeep(log_tkeep),
        .log_tlast(log_tlast), .log_dropped(log_dropped),
        .pkt_passed(pkt_passed), .pkt_dropped(pkt_dropped)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle with a valid flit: check handshake/data before the edge, log after it.
    task automatic cyc(input string tag, input logic [DW-1:0] d, input logic l, input logic mr,
                       input logic e_rdy, input logic e_mv, input logic e_lv, input logic e_ld);
        s_tdata  = d;
        s_tkeep  = {KW{1'b1}};
        s_tlast  = l;
        s_tvalid = 1'b1;
        m_tready = mr;
        #1;
        chk({tag, ".s_tready"}, 64'(s_tready), 64'(e_rdy));
        chk({tag, ".m_tvalid"}, 64'(m_tvalid), 64'(e_mv));
        chk({tag, ".m_tdata"},  64'(m_tdata),  64'(d));
        chk({tag, ".m_tlast"},  64'(m_tlast),  64'(l));
        @(posedge clk);
        #1;
        chk({tag, ".log_valid"}, 64'(log_valid), 64'(e_lv));
        if (e_lv) begin
            chk({tag, ".log_tdata"},   64'(log_tdata),   64'(d));
            chk({tag, ".log_tlast"},   64'(log_tlast),   64'(l));
            chk({tag, ".log_tkeep"},   64'(log_tkeep),   64'hFF);
            chk({tag, ".log_dropped"}, 64'(log_dropped), 64'(e_ld));
        end
    endtask

    initial begin
        rstn = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        m_tready = 1'b1; pause = 1'b0; drop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pkt_passed",  64'(pkt_passed),  64'd0);
        chk("rst.pkt_dropped", 64'(pkt_dropped), 64'd0);
        chk("rst.log_valid",   64'(log_valid),   64'd0);
        rstn = 1'b1;

        // Plain pass-through of a 3-flit packet
        cyc("pass0", 64'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("pass1", 64'h22, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("pass2", 64'h33, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("pass.pkt_passed", 64'(pkt_passed), 64'd1);

        // Pause raised after the first flit does not cut the packet
        cyc("mpause0", 64'h41, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        pause = 1'b1;
        cyc("mpause1", 64'h42, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("mpause2", 64'h43, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("mpause3", 64'h44, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mpause.pkt_passed", 64'(pkt_passed), 64'd2);
        cyc("paused0", 64'h51, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("paused1", 64'h51, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        pause = 1'b0;
        cyc("release", 64'h51, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("release.pkt_passed", 64'(pkt_passed), 64'd3);

        // Drop with downstream stalled; drop released mid-packet still drops all of it
        drop = 1'b1;
        cyc("drop0", 64'h61, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drop = 1'b0;
        cyc("drop1", 64'h62, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("drop.pkt_dropped", 64'(pkt_dropped), 64'd1);
        chk("drop.pkt_passed",  64'(pkt_passed),  64'd3);

        // Backpressure in pass mode: ready mirrors m_tready, nothing lost or repeated
        cyc("bp0", 64'h70, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("bp1", 64'h70, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("bp2", 64'h71, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("bp3", 64'h71, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("bp.pkt_passed", 64'(pkt_passed), 64'd4);

        // Pause beats drop
        pause = 1'b1; drop = 1'b1;
        cyc("prio", 64'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("prio.pkt_dropped", 64'(pkt_dropped), 64'd1);
        pause = 1'b0;
        cyc("single_drop", 64'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("single_drop.pkt_dropped", 64'(pkt_dropped), 64'd2);
        drop = 1'b0;

        // Reset in the middle of a packet abandons it
        cyc("rstmid0", 64'h91, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        cyc("rstmid1", 64'h92, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        rstn = 1'b0;
        #1;
        chk("rstmid.pkt_passed",  64'(pkt_passed),  64'd0);
        chk("rstmid.pkt_dropped", 64'(pkt_dropped), 64'd0);
        chk("rstmid.log_valid",   64'(log_valid),   64'd0);
        chk("rstmid.in_pkt",      64'(dut.in_pkt),  64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drop = 1'b1;
        cyc("post_rst0", 64'h93, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc("post_rst1", 64'h94, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("post_rst.pkt_dropped", 64'(pkt_dropped), 64'd1);
        chk("post_rst.pkt_passed",  64'(pkt_passed),  64'd0);

        // Idle input: no valid, no log pulse
        drop = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("idle.m_tvalid", 64'(m_tvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("idle.log_valid", 64'(log_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
